// File: rtl/aes50_io_reset_seq_if.sv
// Handshake bundle between the AES50 IO reset sequencer and its environment.
// The sequencer is the slave: it takes restart/pll_lock and drives the resets and status.
interface aes50_io_reset_seq_if;
    logic       restart;
    logic       pll_lock;
    logic       pll_rst;
    logic       clk_ddr_reset;
    logic       txd_reset;
    logic       rxd_reset;
    logic       ready;
    logic [2:0] state;
    logic       lock_err;

    modport master (
        output restart,
        output pll_lock,
        input  pll_rst,
        input  clk_ddr_reset,
        input  txd_reset,
        input  rxd_reset,
        input  ready,
        input  state,
        input  lock_err
    );

    modport slave (
        input  restart,
        input  pll_lock,
        output pll_rst,
        output clk_ddr_reset,
        output txd_reset,
        output rxd_reset,
        output ready,
        output state,
        output lock_err
    );
endinterface

// File: rtl/aes50_io_reset_seq.sv
// AES50 IO reset sequencer: PLL reset, settle/lock wait, then ordered release of the DDR
// clock-out, RMII TX and RMII RX gearbox resets. AES50_SEQ_LOCK_EN adds PLL lock monitoring.
module aes50_io_reset_seq #(
    parameter int unsigned PLL_RST_CYCLES     = 16,
    parameter int unsigned LOCK_WAIT_CYCLES   = 1024,
    parameter int unsigned LOCK_STABLE_CYCLES = 64,
    parameter int unsigned GAP_CYCLES         = 4
) (
    input logic                 clk,
    input logic                 reset_n,
    aes50_io_reset_seq_if.slave io
);

    typedef enum logic [2:0] {
        StPllRst  = 3'd0,
        StPllWait = 3'd1,
        StTxRel   = 3'd2,
        StRxRel   = 3'd3,
        StRun     = 3'd4,
        StFault   = 3'd5
    } state_e;

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned MaxCycles = max2(max2(PLL_RST_CYCLES, LOCK_WAIT_CYCLES),
                                             max2(LOCK_STABLE_CYCLES, GAP_CYCLES));
    localparam int unsigned CntW = $clog2(MaxCycles) + 1;

    localparam logic [CntW-1:0] PllRstLast   = CntW'(PLL_RST_CYCLES - 1);
    localparam logic [CntW-1:0] LockWaitLast = CntW'(LOCK_WAIT_CYCLES - 1);
    localparam logic [CntW-1:0] GapLast      = CntW'(GAP_CYCLES - 1);

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            entry;
    logic            counting;

    logic pll_rst_q, pll_rst_d;
    logic clk_ddr_reset_q, clk_ddr_reset_d;
    logic txd_reset_q, txd_reset_d;
    logic rxd_reset_q, rxd_reset_d;
    logic ready_q, ready_d;

    // Lock monitor: stability counter plus lock-loss detection while the IO path is live.
`ifdef AES50_SEQ_LOCK_EN
    localparam int unsigned      StabW    = $clog2(LOCK_STABLE_CYCLES) + 1;
    localparam logic [StabW-1:0] StabLast = StabW'(LOCK_STABLE_CYCLES - 1);

    logic [StabW-1:0] stab_q, stab_d;
    logic             stab_done;
    logic             lock_lost;
    logic             lock_err_q, lock_err_d;

    assign stab_done = io.pll_lock && (stab_q == StabLast);
    assign lock_lost = !io.pll_lock && (state_q inside {StTxRel, StRxRel, StRun});

    always_comb begin
        stab_d = stab_q;
        if (entry || !io.pll_lock) begin
            stab_d = '0;
        end else if ((state_q == StPllWait) && !stab_done) begin
            stab_d = stab_q + StabW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stab_q     <= '0;
            lock_err_q <= 1'b0;
        end else begin
            stab_q     <= stab_d;
            lock_err_q <= lock_err_d;
        end
    end

    assign io.lock_err = lock_err_q;
`else
    logic unused_pll_lock;
    assign unused_pll_lock = io.pll_lock;
    assign io.lock_err     = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            StPllRst: begin
                if (cnt_q == PllRstLast) state_d = StPllWait;
            end
            StPllWait: begin
`ifdef AES50_SEQ_LOCK_EN
                if (stab_done) begin
                    state_d = StTxRel;
                end else if (cnt_q == LockWaitLast) begin
                    state_d = StFault;
                end
`else
                if (cnt_q == LockWaitLast) state_d = StTxRel;
`endif
            end
            StTxRel: begin
                if (cnt_q == GapLast) state_d = StRxRel;
            end
            StRxRel: begin
                if (cnt_q == GapLast) state_d = StRun;
            end
            StRun: begin
                state_d = StRun;
            end
`ifdef AES50_SEQ_LOCK_EN
            StFault: begin
                state_d = StFault;
            end
`endif
            default: begin
                state_d = StPllRst;
            end
        endcase

`ifdef AES50_SEQ_LOCK_EN
        if (lock_lost) state_d = StPllRst;
`endif
        if (io.restart) state_d = StPllRst;
    end

    // A restart while already in PLL_RST must still restart the hold time.
    assign entry    = io.restart || (state_d != state_q);
    assign counting = state_q inside {StPllRst, StPllWait, StTxRel, StRxRel};

    always_comb begin
        cnt_d = cnt_q;
        if (entry) begin
            cnt_d = '0;
        end else if (counting) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    // Outputs are decoded from the next state so they change on the entering edge.
    always_comb begin
        pll_rst_d       = 1'b1;
        clk_ddr_reset_d = 1'b1;
        txd_reset_d     = 1'b1;
        rxd_reset_d     = 1'b1;
        ready_d         = 1'b0;
`ifdef AES50_SEQ_LOCK_EN
        lock_err_d      = 1'b0;
`endif
        case (state_d)
            StPllWait: begin
                pll_rst_d = 1'b0;
            end
            StTxRel: begin
                pll_rst_d       = 1'b0;
                clk_ddr_reset_d = 1'b0;
                txd_reset_d     = 1'b0;
            end
            StRxRel: begin
                pll_rst_d       = 1'b0;
                clk_ddr_reset_d = 1'b0;
                txd_reset_d     = 1'b0;
                rxd_reset_d     = 1'b0;
            end
            StRun: begin
                pll_rst_d       = 1'b0;
                clk_ddr_reset_d = 1'b0;
                txd_reset_d     = 1'b0;
                rxd_reset_d     = 1'b0;
                ready_d         = 1'b1;
            end
`ifdef AES50_SEQ_LOCK_EN
            StFault: begin
                pll_rst_d  = 1'b0;
                lock_err_d = 1'b1;
            end
`endif
            default: begin
                pll_rst_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= StPllRst;
            cnt_q           <= '0;
            pll_rst_q       <= 1'b1;
            clk_ddr_reset_q <= 1'b1;
            txd_reset_q     <= 1'b1;
            rxd_reset_q     <= 1'b1;
            ready_q         <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            pll_rst_q       <= pll_rst_d;
            clk_ddr_reset_q <= clk_ddr_reset_d;
            txd_reset_q     <= txd_reset_d;
            rxd_reset_q     <= rxd_reset_d;
            ready_q         <= ready_d;
        end
    end

    assign io.pll_rst       = pll_rst_q;
    assign io.clk_ddr_reset = clk_ddr_reset_q;
    assign io.txd_reset     = txd_reset_q;
    assign io.rxd_reset     = rxd_reset_q;
    assign io.ready         = ready_q;
    assign io.state         = state_q;

endmodule
